// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bundle for fp_addsub_pipe: input handshake, output handshake and status flags.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         add_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         inf;
  logic         nan;
  logic         subnormal;

  modport master (
    output in_valid, x, y, add_sub, out_ready,
    input  in_ready, out_valid, r, negative, zero, overflow, inf, nan, subnormal
  );

  modport slave (
    input  in_valid, x, y, add_sub, out_ready,
    output in_ready, out_valid, r, negative, zero, overflow, inf, nan, subnormal
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// 3-stage pipelined floating-point add/subtract (align, add, normalise/round/pack).
// Define FP_ADDSUB_FTZ_EN to flush subnormal inputs and results to signed zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic clk,
  input logic rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;  // significand with hidden bit
  localparam int AW   = MAN_W + 3;  // significand + guard + round
  localparam int PW   = MAN_W + 4;  // + sticky
  localparam int SUMW = MAN_W + 5;  // + carry
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      EXP_MAX  = (32'd1 << EXP_W) - 32'd1;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // The whole pipe advances together; it stalls only when the output holds an unaccepted result.
  logic adv;
  logic out_valid_q;
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- S1: unpack, compare, align ----------------
  logic             xs, ys, x_nan, y_nan, x_inf, y_inf, x_ge;
  logic [EXP_W-1:0] xe, ye, xee, yee, g_exp, l_exp, diff;
  logic [MAN_W-1:0] xm, ym, xm_f, ym_f;
  logic [SW-1:0]    xsig, ysig, g_sig, l_sig;
  logic [AW-1:0]    ext, shifted;
  logic [31:0]      diff_w;
  logic             stk, g_sign;

  always_comb begin
    xs = bus.x[W-1];
    xe = bus.x[W-2:MAN_W];
    xm = bus.x[MAN_W-1:0];
    ys = bus.y[W-1] ^ bus.add_sub;
    ye = bus.y[W-2:MAN_W];
    ym = bus.y[MAN_W-1:0];
    x_nan = (xe == EXP_ONES) && (xm != '0);
    y_nan = (ye == EXP_ONES) && (ym != '0);
    x_inf = (xe == EXP_ONES) && (xm == '0);
    y_inf = (ye == EXP_ONES) && (ym == '0);
`ifdef FP_ADDSUB_FTZ_EN
    xm_f = (xe == '0) ? '0 : xm;
    ym_f = (ye == '0) ? '0 : ym;
`else
    xm_f = xm;
    ym_f = ym;
`endif
    xsig = {xe != '0, xm_f};
    ysig = {ye != '0, ym_f};
    xee  = (xe == '0) ? EXP_ONE : xe;
    yee  = (ye == '0) ? EXP_ONE : ye;
    x_ge = (xee > yee) || ((xee == yee) && (xsig >= ysig));
    g_sign = x_ge ? xs : ys;
    g_exp  = x_ge ? xee : yee;
    g_sig  = x_ge ? xsig : ysig;
    l_exp  = x_ge ? yee : xee;
    l_sig  = x_ge ? ysig : xsig;
    diff   = g_exp - l_exp;
    diff_w = 32'(diff);
    ext    = {l_sig, 2'b00};
    if (diff_w >= 32'(AW)) begin
      shifted = '0;
      stk     = |l_sig;
    end else begin
      shifted = ext >> diff;
      stk     = |(ext & ~({AW{1'b1}} << diff));
    end
  end

  // ---------------- S2: add / subtract ----------------
  logic             s1_valid, s1_sign, s1_eff_sub, s1_nan, s1_inf, s1_inf_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [PW-1:0]    s1_g, s1_l;
  logic [SUMW-1:0]  sum_c;

  always_comb begin
    if (s1_eff_sub) sum_c = {1'b0, s1_g} - {1'b0, s1_l};
    else            sum_c = {1'b0, s1_g} + {1'b0, s1_l};
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic             s2_valid, s2_sign, s2_eff_sub, s2_nan, s2_inf, s2_inf_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [SUMW-1:0]  s2_sum;
  logic [PW-1:0]    m0, m;
  logic [31:0]      lz, sh, exp32, e_n, e_f;
  logic [SW:0]      sig_r;
  logic [SW-1:0]    sig_f;
  logic             round_up, ovf, res_sign;
  logic [W-1:0]     r_c;

  always_comb begin
    m0    = s2_sum[PW-1:0];
    exp32 = 32'(s2_exp);
    lz    = 32'(PW);
    for (int i = 0; i < PW; i++) begin
      if (m0[i]) lz = 32'(PW - 1 - i);
    end
    sh = '0;
    if (s2_sum[SUMW-1]) begin
      m   = {s2_sum[SUMW-1:2], s2_sum[1] | s2_sum[0]};
      e_n = exp32 + 32'd1;
    end else begin
      // Never normalise below exponent 1; stopping there leaves a subnormal.
      sh  = (lz > exp32 - 32'd1) ? exp32 - 32'd1 : lz;
      m   = m0 << sh;
      e_n = exp32 - sh;
    end
    round_up = m[2] & (m[1] | m[0] | m[3]);
    sig_r    = {1'b0, m[PW-1:3]} + {{SW{1'b0}}, round_up};
    if (sig_r[SW]) begin
      sig_f = sig_r[SW:1];
      e_f   = e_n + 32'd1;
    end else begin
      sig_f = sig_r[SW-1:0];
      e_f   = e_n;
    end
    ovf = sig_f[MAN_W] && (e_f >= EXP_MAX);
    // Exact cancellation gives +0; only like-signed zero addition keeps the sign.
    res_sign = (sig_f == '0 && s2_eff_sub) ? 1'b0 : s2_sign;
    if (s2_nan)             r_c = {1'b0, EXP_ONES, {MAN_W{1'b1}}};
    else if (s2_inf)        r_c = {s2_inf_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (ovf)           r_c = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (sig_f[MAN_W])  r_c = {res_sign, e_f[EXP_W-1:0], sig_f[MAN_W-1:0]};
`ifdef FP_ADDSUB_FTZ_EN
    else                    r_c = {res_sign, {(EXP_W+MAN_W){1'b0}}};
`else
    else                    r_c = {res_sign, {EXP_W{1'b0}}, sig_f[MAN_W-1:0]};
`endif
  end

  // ---------------- pipeline registers ----------------
  logic [W-1:0] r_q;
  logic         neg_q, zero_q, ovf_q, inf_q, nan_q, sub_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      inf_q       <= 1'b0;
      nan_q       <= 1'b0;
      sub_q       <= 1'b0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      s1_sign     <= g_sign;
      s1_exp      <= g_exp;
      s1_g        <= {g_sig, 3'b000};
      s1_l        <= {shifted, stk};
      s1_eff_sub  <= xs ^ ys;
      s1_nan      <= x_nan | y_nan | (x_inf & y_inf & (xs ^ ys));
      s1_inf      <= x_inf | y_inf;
      s1_inf_sign <= x_inf ? xs : ys;

      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_c;
      s2_eff_sub  <= s1_eff_sub;
      s2_nan      <= s1_nan;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;

      out_valid_q <= s2_valid;
      r_q         <= r_c;
      neg_q       <= r_c[W-1];
      zero_q      <= (r_c[W-2:0] == '0);
      ovf_q       <= ovf & ~s2_nan & ~s2_inf;
      inf_q       <= (r_c[W-2:MAN_W] == EXP_ONES) && (r_c[MAN_W-1:0] == '0);
      nan_q       <= (r_c[W-2:MAN_W] == EXP_ONES) && (r_c[MAN_W-1:0] != '0);
      sub_q       <= (r_c[W-2:MAN_W] == '0) && (r_c[MAN_W-1:0] != '0);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.inf       = inf_q;
  assign bus.nan       = nan_q;
  assign bus.subnormal = sub_q;
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. Default format is half precision; any exponent/mantissa width is supported.
- Fixed 3-stage pipeline with a valid/ready handshake on both sides and full backpressure.
- Returns the result plus status flags for the CPSR logic in the ALU datapath.
- Successor to the combinational half-precision adder. Adds format generality, pipelining, flow control, correct subnormal exponent handling and a true sticky bit.

Parameters:
EXP_W, 5, exponent field width (>=3)
MAN_W, 10, stored mantissa field width (>=2); word width W = 1+EXP_W+MAN_W

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  pipeline can accept operands this cycle
x  input  W  operand A
y  input  W  operand B
add_sub  input  1  0 = x+y, 1 = x-y (inverts y sign)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
r  output  W  result
negative  output  1  r sign bit
zero  output  1  r magnitude is zero
overflow  output  1  finite operands produced infinity
inf  output  1  r is ±infinity
nan  output  1  r is NaN
subnormal  output  1  r is subnormal (exp 0, mantissa nonzero)

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits 0. out_valid=0, r=0, all flags 0. Any in-flight operations are discarded; rst wins over a simultaneous in_valid.
- Pipeline control:
  - Global enable `adv = ~out_valid | out_ready`; `in_ready = adv`.
  - Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
  - When adv=0, every stage holds. r and the flags stay stable while out_valid & ~out_ready.
  - Bubbles are not squeezed.
- Latency: exactly 3 cycles from input acceptance to out_valid when there is no stall. Throughput is 1 per cycle. Results leave in order.
- S1 (unpack/compare/align):
  - Operands are split into sign, exponent and mantissa; effective y sign = y[W-1]^add_sub.
  - Implicit bit = (exp!=0). Effective exponent = exp, or 1 when exp==0 (subnormal).
  - Swap so the larger magnitude is the "greater" operand: compare exponent first, then significand.
  - Right-shift the lesser significand by the exponent difference into MAN_W+1 significand bits plus guard, round and sticky. Sticky is the OR of all bits shifted beyond round.
  - A shift >= MAN_W+3 leaves only sticky = OR(significand).
  - Special-case detection happens here and is carried down the pipe.
- S2 (add):
  - effective_sub = sign XOR.
  - Compute greater ± aligned with MAN_W+5 bits, including carry. The result is non-negative by construction; result sign = greater sign.
- S3 (normalise/round/pack):
  - On carry, shift right 1, folding the dropped bit into sticky, and increment the exponent.
  - Otherwise left-normalise by the leading-zero count, limited so the exponent does not go below 1. If the limit is hit, the result is subnormal and the packed exponent is 0.
  - Round to nearest, ties to even, on guard/(round|sticky)/LSB.
  - A mantissa carry-out on rounding increments the exponent; a subnormal that rounds up to normal yields exponent 1.
  - Exponent reaching all-ones gives ±inf with overflow=1.
- Special cases, in priority order:
  1. Any NaN input gives canonical NaN {0, all-ones, all-ones}.
  2. inf−inf (effective) gives canonical NaN.
  3. inf ± finite, or like-signed infs, gives the inf with its effective sign.
- Zero sign:
  - An exact zero from effective subtraction is +0.
  - (−0)+(−0) is −0.
- Flags are computed from packed r. overflow is set only for a non-special overflow.

Optional Feature:
FP_ADDSUB_FTZ_EN
- Defined: subnormal inputs are treated as zero of the same sign in S1. Subnormal results are flushed to zero of the result sign in S3, so subnormal is never 1.
- Not defined: full gradual-underflow handling as specified above.

Test Plan:
- Default params, x=0x3C00, y=0x3C00, add_sub=0, out_ready=1 → r=0x4000 exactly 3 cycles after acceptance; all flags 0.
- x=0x3C00, y=0x3C00, add_sub=1 → r=0x0000, zero=1, negative=0. x=0x8000, y=0x8000, add_sub=0 → r=0x8000, zero=1, negative=1.
- Rounding:
  - x=0x3C00, y=0x1000 (tie, LSB even) → r=0x3C00.
  - x=0x3C01, y=0x1000 (tie, LSB odd) → r=0x3C02.
  - x=0x0001, y=0x0001 → r=0x0002, subnormal=1.
- Specials:
  - x=0x7BFF, y=0x7BFF → r=0x7C00, overflow=1, inf=1.
  - x=0x7C00, y=0x7C00, add_sub=1 → r=0x7FFF, nan=1, overflow=0.
  - x=0x7E00, y=0x3C00 → r=0x7FFF.
- Backpressure:
  - Issue 6 back-to-back ops, hold out_ready=0 for 5 cycles after the first out_valid. Required: in_ready=0 during the hold, r held stable, all 6 results delivered in order, none lost or duplicated.
  - Assert rst mid-stream → next cycle out_valid=0, r=0; no stale results appear afterwards.
